// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the ram_bank storage block and its wrappers.
package ram_pkg;

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  function automatic int unsigned calc_depth(int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned calc_be_w(int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned DefaultDataW = 64;
  localparam int unsigned DefaultAddrW = 8;
  localparam int unsigned BE_W         = calc_be_w(DefaultDataW);

endpackage

// File: rtl/ram_bank_if.sv
// Host-side access bus of ram_bank: request, write data/enables, read response and busy.
interface ram_bank_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8
);
  import ram_pkg::*;

  localparam int unsigned BeW = calc_be_w(DATA_W);

  logic              cen;
  logic              wen;
  logic [BeW-1:0]    s_be;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
  logic              s_valid;
  logic              busy;

  modport master (
    output cen, wen, s_be, s_addr, s_din,
    input  s_dout, s_valid, busy
  );

  modport slave (
    input  cen, wen, s_be, s_addr, s_din,
    output s_dout, s_valid, busy
  );

endinterface

// File: rtl/ram_core.sv
// Plain single-port array with per-byte write enables and a registered read port.
module ram_core
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic                        re_i,
  input  logic [calc_be_w(DATA_W)-1:0] be_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int unsigned Depth = calc_depth(ADDR_W);
  localparam int unsigned BeW   = calc_be_w(DATA_W);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  // Storage is deliberately not reset; the wrapper's clear sequence zero-fills it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < BeW; k++) begin
        if (be_i[k]) begin
          mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bank.sv
// Single-port RAM with byte enables, read-valid strobe, optional output register and a
// post-reset zero-fill sequencer that holds off host accesses while it runs.
module ram_bank
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned OUT_REG = 0
) (
  input  logic     clk,
  input  logic     rst,
  ram_bank_if.slave bus
);

  localparam int unsigned BeW = calc_be_w(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rd_vld_q, rd_vld_d;

  logic              core_we;
  logic              core_re;
  logic [BeW-1:0]    core_be;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  // Clear FSM and the write mux that hands the array to either the sequencer or the host.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_be    = '0;
    core_addr  = bus.s_addr;
    core_wdata = bus.s_din;
    unique case (state_q)
      StClear: begin
        core_we    = 1'b1;
        core_be    = '1;
        core_addr  = clr_cnt_q;
        core_wdata = '0;
        clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == '1) begin
          state_d = StReady;
        end
      end
      StReady: begin
        core_we = bus.cen & bus.wen;
        core_re = bus.cen & ~bus.wen;
        core_be = bus.s_be;
      end
      default: state_d = StClear;
    endcase
    rd_vld_d = core_re;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i   (clk),
    .we_i    (core_we),
    .re_i    (core_re),
    .be_i    (core_be),
    .addr_i  (core_addr),
    .wdata_i (core_wdata),
    .rdata_o (core_rdata)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
      out_vld_d  = rd_vld_q;
      out_data_d = rd_vld_q ? core_rdata : '0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q  <= out_vld_d;
        out_data_q <= out_data_d;
      end
    end

    assign bus.s_valid = out_vld_q;
    assign bus.s_dout  = out_data_q;
  end else begin : g_no_out_reg
    // Stale array output is masked so idle and write cycles read as zero.
    assign bus.s_valid = rd_vld_q;
    assign bus.s_dout  = rd_vld_q ? core_rdata : '0;
  end

  assign bus.busy = (state_q == StClear);

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank: three configurations driven in lock-step, checked against an array model.
module tb_ram_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b1;
  logic        cen  = 1'b0;
  logic        wen  = 1'b0;
  logic [7:0]  be   = 8'h00;
  logic [7:0]  addr = 8'h00;
  logic [63:0] din  = 64'h0;

  // a: 64x256 latency 1, b: 32x16 latency 2, c: 64x256 latency 2
  ram_bank_if #(.DATA_W(64), .ADDR_W(8)) ifa ();
  ram_bank_if #(.DATA_W(32), .ADDR_W(4)) ifb ();
  ram_bank_if #(.DATA_W(64), .ADDR_W(8)) ifc ();

  assign ifa.cen = cen;  assign ifa.wen = wen;  assign ifa.s_be = be;
  assign ifa.s_addr = addr;  assign ifa.s_din = din;
  assign ifb.cen = cen;  assign ifb.wen = wen;  assign ifb.s_be = be[3:0];
  assign ifb.s_addr = addr[3:0];  assign ifb.s_din = din[31:0];
  assign ifc.cen = cen;  assign ifc.wen = wen;  assign ifc.s_be = be;
  assign ifc.s_addr = addr;  assign ifc.s_din = din;

  ram_bank #(.DATA_W(64), .ADDR_W(8), .OUT_REG(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  ram_bank #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  ram_bank #(.DATA_W(64), .ADDR_W(8), .OUT_REG(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] mdl_mem [3][256];
  int          busy_left [3];
  logic        exp_v [3][4];
  logic [63:0] exp_d [3][4];

  typedef struct {
    logic        c;
    logic        w;
    logic [7:0]  be;
    logic [7:0]  addr;
    logic [63:0] din;
    logic        ev;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl [14];

  function automatic int inst_aw(int i);
    return (i == 1) ? 4 : 8;
  endfunction

  function automatic int inst_dw(int i);
    return (i == 1) ? 32 : 64;
  endfunction

  function automatic int inst_lat(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, inst, cyc, got, exp);
    end
  endtask

  task automatic get_act(input int i, output logic v, output logic [63:0] d, output logic b);
    case (i)
      0:       begin v = ifa.s_valid; d = ifa.s_dout;      b = ifa.busy; end
      1:       begin v = ifb.s_valid; d = 64'(ifb.s_dout); b = ifb.busy; end
      default: begin v = ifc.s_valid; d = ifc.s_dout;      b = ifc.busy; end
    endcase
  endtask

  // Reference: busy lasts DEPTH cycles after reset, reads answer after their latency.
  task automatic model_update(input logic r, input logic c, input logic w, input logic [7:0] b,
                              input logic [7:0] a, input logic [63:0] d);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] wa;
      int         t;
      wa = a & 8'((1 << inst_aw(i)) - 1);
      if (r) begin
        busy_left[i] = 1 << inst_aw(i);
        for (int s = 0; s < 4; s++) exp_v[i][s] = 1'b0;
        for (int j = 0; j < 256; j++) mdl_mem[i][j] = 64'h0;
      end else if (busy_left[i] > 0) begin
        busy_left[i]--;
      end else if (c && w) begin
        for (int k = 0; k < inst_dw(i) / 8; k++) begin
          if (b[k]) mdl_mem[i][wa][8*k +: 8] = d[8*k +: 8];
        end
      end else if (c) begin
        t = (cyc + inst_lat(i) - 1) % 4;
        exp_v[i][t] = 1'b1;
        exp_d[i][t] = mdl_mem[i][wa];
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      logic        v;
      logic [63:0] dd;
      logic        bz;
      int          s;
      s = cyc % 4;
      get_act(i, v, dd, bz);
      chk("busy", i, 64'(bz), 64'(busy_left[i] > 0));
      chk("valid", i, 64'(v), 64'(exp_v[i][s]));
      chk("dout", i, dd, exp_v[i][s] ? exp_d[i][s] : 64'h0);
      exp_v[i][s] = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic [7:0] b,
                      input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    rst = r; cen = c; wen = w; be = b; addr = a; din = d;
    @(posedge clk);
    model_update(r, c, w, b, a, d);
    #1;
    model_check();
  endtask

  // Called right after a reset step; counts cycles with busy high, bounded.
  task automatic run_clear(input logic wr_ff, output int n0, output int n1, output int n2);
    n0 = ifa.busy ? 1 : 0;
    n1 = ifb.busy ? 1 : 0;
    n2 = ifc.busy ? 1 : 0;
    for (int t = 0; t < 400; t++) begin
      if (!ifa.busy && !ifb.busy && !ifc.busy) break;
      step(1'b0, wr_ff, 1'b1, 8'hFF, 8'h05, 64'hFFFF_FFFF_FFFF_FFFF);
      if (ifa.busy) n0++;
      if (ifb.busy) n1++;
      if (ifc.busy) n2++;
    end
  endtask

  initial begin
    int          n0, n1, n2;
    logic        v, bz;
    logic [63:0] d;

    for (int i = 0; i < 3; i++) begin
      busy_left[i] = 0;
      for (int s = 0; s < 4; s++) begin exp_v[i][s] = 1'b0; exp_d[i][s] = 64'h0; end
    end

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 64'h0, 1'b1, 64'h0};
    tbl[1]  = '{1'b1, 1'b0, 8'hFF, 8'h80, 64'h0, 1'b1, 64'h0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'hFF, 64'h0, 1'b1, 64'h0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'h05, 64'h0, 1'b1, 64'h0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0, 64'h0};
    tbl[5]  = '{1'b1, 1'b1, 8'hFF, 8'h10, 64'h1122334455667788, 1'b0, 64'h0};
    tbl[6]  = '{1'b1, 1'b1, 8'h0F, 8'h10, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 8'h10, 64'h0, 1'b1, 64'h11223344AAAAAAAA};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 8'h10, 64'h0, 1'b0, 64'h0};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 8'h20, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0};
    tbl[10] = '{1'b1, 1'b0, 8'hFF, 8'h20, 64'h0, 1'b1, 64'h0};
    tbl[11] = '{1'b1, 1'b1, 8'h81, 8'h30, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 8'h30, 64'h0, 1'b1, 64'hDE0000000000000D};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 8'h10, 64'h0, 1'b1, 64'h11223344AAAAAAAA};

    // Reset, then clear with host writes to addr 5 that must be ignored while busy.
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    run_clear(1'b1, n0, n1, n2);
    chk("clear_len", 0, 64'(n0), 64'd256);
    chk("clear_len", 1, 64'(n1), 64'd16);
    chk("clear_len", 2, 64'(n2), 64'd256);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].c, tbl[i].w, tbl[i].be, tbl[i].addr, tbl[i].din);
      get_act(0, v, d, bz);
      chk("tbl_valid", i, 64'(v), 64'(tbl[i].ev));
      chk("tbl_dout", i, d, tbl[i].ev ? tbl[i].ed : 64'h0);
    end

    // Back-to-back reads: response train position depends only on latency.
    for (int j = 1; j <= 4; j++) step(1'b0, 1'b1, 1'b1, 8'hFF, 8'(j), 64'(j));
    for (int s = 0; s < 6; s++) begin
      if (s < 4) step(1'b0, 1'b1, 1'b0, 8'h00, 8'(s + 1), 64'h0);
      else       step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
      for (int i = 0; i < 3; i++) begin
        int idx;
        idx = s - (inst_lat(i) - 1);
        get_act(i, v, d, bz);
        chk("b2b_valid", i, 64'(v), 64'(idx >= 0 && idx < 4));
        chk("b2b_dout", i, d, (idx >= 0 && idx < 4) ? 64'(idx + 1) : 64'h0);
      end
    end

    // Output zeroing and read-after-write on the small pipelined instance.
    step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h07, 64'h13579BDF);
    get_act(1, v, d, bz);
    chk("wr_resp", 1, {63'h0, v} | d, 64'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    get_act(1, v, d, bz);
    chk("idle_resp", 1, {63'h0, v} | d, 64'h0);
    step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h07, 64'h2468ACE0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 64'h0);
    get_act(1, v, d, bz);
    chk("raw_inflight", 1, {63'h0, v} | d, 64'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    get_act(1, v, d, bz);
    chk("raw_valid", 1, 64'(v), 64'h1);
    chk("raw_dout", 1, d, 64'h2468ACE0);

    // Read then reset: pipelined responses must be dropped.
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 64'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    for (int t = 0; t < 3; t++) begin
      get_act(2, v, d, bz);
      chk("rst_drop_valid", 2, 64'(v), 64'h0);
      chk("rst_busy", 2, 64'(bz), 64'h1);
      get_act(1, v, d, bz);
      chk("rst_drop_valid", 1, 64'(v), 64'h0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    end
    for (int t = 3; t < 99; t++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
    run_clear(1'b0, n0, n1, n2);
    chk("reclear_len", 0, 64'(n0), 64'd256);
    chk("reclear_len", 1, 64'(n1), 64'd16);
    chk("reclear_len", 2, 64'(n2), 64'd256);

    // Random traffic with occasional resets, checked cycle by cycle by the model.
    for (int t = 0; t < 3000; t++) begin
      logic        r, c, w;
      logic [7:0]  a;
      r = ($urandom_range(0, 399) == 0);
      c = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step(r, c, w, 8'($urandom), a, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
